// File: rtl/mag_pkg.sv
// Shared types and constants for the magnitude window statistics block.
// Default widths, FSM state encoding and the running-min reset value.
package mag_pkg;

  localparam int DATA_W_DEF   = 8;
  localparam int LOG2_WIN_DEF = 3;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Wide all-ones; users slice it down to their sample width.
  localparam logic [63:0] MIN_RST = '1;

endpackage

// File: rtl/mag_minmax_acc.sv
// Running sum / max / min over one window of magnitude samples.
// Exposes next values so the top can latch a result on the last accept.
module mag_minmax_acc
  import mag_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       acc,
  input  logic [DATA_W-1:0]          smp,
  output logic                       last,
  output logic [DATA_W+LOG2_WIN-1:0] sum_nx,
  output logic [DATA_W-1:0]          max_nx,
  output logic [DATA_W-1:0]          min_nx
);

  localparam int SUM_W = DATA_W + LOG2_WIN;
  localparam logic [DATA_W-1:0] MINR = MIN_RST[DATA_W-1:0];

  logic [LOG2_WIN-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [DATA_W-1:0]   min_q, min_d;

  assign sum_nx = sum_q + SUM_W'(smp);
  assign max_nx = (smp > max_q) ? smp : max_q;
  assign min_nx = (smp < min_q) ? smp : min_q;
  assign last   = acc & (&cnt_q);

  always_comb begin
    cnt_d = cnt_q;
    sum_d = sum_q;
    max_d = max_q;
    min_d = min_q;
    if (clr || last) begin
      cnt_d = '0;
      sum_d = '0;
      max_d = '0;
      min_d = MINR;
    end else if (acc) begin
      cnt_d = cnt_q + 1'b1;
      sum_d = sum_nx;
      max_d = max_nx;
      min_d = min_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sum_q <= '0;
      max_q <= '0;
      min_q <= MINR;
    end else begin
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      max_q <= max_d;
      min_q <= min_d;
    end
  end

endmodule

// File: rtl/mag_window_stats.sv
// Window average/max/min of magnitude samples with valid/ready handoff.
// Input is stalled while a finished window result waits downstream.
module mag_window_stats
  import mag_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int LOG2_WIN = LOG2_WIN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_mag,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_avg,
  output logic [DATA_W-1:0] out_max,
  output logic [DATA_W-1:0] out_min,
  output logic [7:0]        win_cnt
);

  localparam int SUM_W = DATA_W + LOG2_WIN;

  state_t state_q, state_d;

  logic              clr, acc, last, take;
  logic [SUM_W-1:0]  sum_nx;
  logic [DATA_W-1:0] max_nx, min_nx;
  logic [DATA_W-1:0] avg_q, max_q, min_q;
  logic [7:0]        win_q;

  // clear beats a same-cycle accept; the offered sample is dropped
  assign clr  = ena & clear & (state_q == ACCUM);
  assign acc  = in_valid & in_ready & ~clr;
  assign take = out_valid & out_ready & ena;

  mag_minmax_acc #(
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .acc    (acc),
    .smp    (in_mag),
    .last   (last),
    .sum_nx (sum_nx),
    .max_nx (max_nx),
    .min_nx (min_nx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ACCUM: if (last) state_d = HOLD;
      HOLD:  if (take) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    in_ready  = ena & (state_q == ACCUM);
    out_valid = (state_q == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      avg_q <= '0;
      max_q <= '0;
      min_q <= '0;
    end else if (last) begin
      avg_q <= DATA_W'(sum_nx >> LOG2_WIN);
      max_q <= max_nx;
      min_q <= min_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       win_q <= '0;
    else if (take) win_q <= win_q + 8'd1;
  end

  assign out_avg = avg_q;
  assign out_max = max_q;
  assign out_min = min_q;
  assign win_cnt = win_q;

endmodule
